wb_scaler_bank: RTL and testbench
=================================

Name: wb_scaler_bank

Overview:
- Single-clock bank of trigger-rate scalers with an 8-bit Wishbone slave readout port.
- Counts L1 (TDA and reserved), L2, L2.5 and top-level trigger flags between PPS flags.
- On each PPS flag it snapshots the counts into readout registers and restarts counting.
- Sits on the station Wishbone bus in the scaler address window; only adr_i[7:0] is decoded.

Parameters:
NUM_DAUGHTERS, 4, populated daughterboards (1..4); absent daughters read 0.
L1_PRESCALE_BITS, 5, L1 counters are 16+5 bits; readout is the top 16 bits (count/32).
L2_PRESCALE_BITS, 0, extra LSBs on L2 counters.
L2_5_PRESCALE_BITS, 0, extra LSBs on L2.5 counters.
TOP_PRESCALE_BITS, 0, extra LSBs on both top counters.

Ports:
clk_i  in  1  sole clock (Wishbone and counting)
rst_i  in  1  synchronous, active-high reset
cyc_i  in  1  Wishbone cycle
stb_i  in  1  Wishbone strobe
wr_i  in  1  write enable (writes accepted and ignored)
adr_i  in  16  address; only [7:0] decoded
dat_i  in  8  write data (unused)
dat_o  out  8  read data
ack_o  out  1  acknowledge
err_o  out  1  constant 0
rty_o  out  1  constant 0
tda_scal_i  in  16  L1 TDA flags, bit 4*d+c = daughter d, channel c
rsv_scal_i  in  16  L1 reserved flags, same packing
l2_scal_i  in  16  L2 flags
l2_5_scal_i  in  2  L2.5 flags
top_self_i  in  1  top RF trigger flag
top_surf_i  in  1  top surface trigger flag
pps_flag_i  in  1  one-cycle PPS pulse
debug_counter  out  16  live L2 counter 12, low 16 bits

Behaviour:
- Reset: all counters, latches, readout registers and the update flag clear to 0. dat_o reads 0 everywhere. ack_o still follows cyc_i&stb_i. Reset has priority over all other events.
- Counting is level-based: each clock an input is 1, its counter increments by 1.
- Counters saturate at all-ones and do not wrap.
- PPS cycle (pps_flag_i=1): every counter loads 0 and its latch captures the pre-clear value. An input event in the PPS cycle is dropped.
- Update flag: update_q <= pps_flag_i. When update_q=1, readout registers <= latches, one cycle after PPS.
- Readout registers are valid from the second edge after PPS and hold until the next update.
- Back-to-back PPS pulses: each latches the then-current count; a zero count is legal.
- Readout value per scaler: the top 16 bits of the readout register, i.e. count >> PRESCALE_BITS.
- ack_o = cyc_i & stb_i (combinational, zero wait states). err_o = rty_o = 0.
- dat_o is combinational on adr_i[7:0]. adr_i[0]=0 gives the low byte; adr_i[0]=1 gives the high byte.
- Address map:
  - 0x00-0x1F: TDA, daughter adr[4:3], channel adr[2:1].
  - 0x20-0x3F: L2 index adr[4:1]; all 16 are implemented.
  - 0x40-0x5F: reserved, daughter adr[4:3], channel adr[2:1].
  - 0x60-0x61: top self.
  - 0x62-0x63: top surface.
  - 0x64-0x67: L2.5 index adr[1].
  - 0x68-0xFF: read 0.
- Daughter index >= NUM_DAUGHTERS reads 0.
- Writes: acked, no state change.
- debug_counter is the live (not latched) L2 counter 12; it saturates and clears like the counter.

Test Plan:
1. Reset, then read 0x00-0x67 -> all bytes 0x00, and ack_o=1 on every cyc_i&stb_i.
2. tda_scal_i[5] (daughter 1, channel 1) high for 64 cycles, then PPS, wait 2 cycles -> 0x0A reads 0x02 and 0x0B reads 0x00. After a second PPS with no input, both read 0x00.
3. l2_scal_i[3] high for 70000 cycles, then PPS -> 0x26/0x27 read 0xFF/0xFF (saturated). debug_counter stays 0 throughout.
4. l2_scal_i[12] high for 300 cycles including the PPS cycle, PPS on cycle 200 -> 0x38/0x39 read 0xC8/0x00. debug_counter = 99 after the burst.
5. top_self_i for 5 cycles, top_surf_i for 7, l2_5_scal_i[1] for 9, then PPS -> 0x60=0x05, 0x62=0x07, 0x66=0x09, all high bytes 0x00. A write to 0x60 is acked and the value is unchanged.
6. rst_i asserted mid-count, before any PPS and again after a latched value -> readouts and debug_counter return to 0 on the next edge. Address 0x70 reads 0x00.

Source files
------------

// File: rtl/wb_scaler_bank_if.sv
// Wishbone slave bus bundle for the scaler bank readout port.
interface wb_scaler_bank_if;
  logic        cyc_i;
  logic        stb_i;
  logic        wr_i;
  logic [15:0] adr_i;
  logic [7:0]  dat_i;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  cyc_i, stb_i, wr_i, adr_i, dat_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output cyc_i, stb_i, wr_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_scaler_bank.sv
// Trigger-rate scaler bank: saturating counters snapshotted on PPS,
// read back as 16-bit values over an 8-bit zero-wait-state Wishbone port.
module wb_scaler_bank #(
  parameter int unsigned NUM_DAUGHTERS      = 4,
  parameter int unsigned L1_PRESCALE_BITS   = 5,
  parameter int unsigned L2_PRESCALE_BITS   = 0,
  parameter int unsigned L2_5_PRESCALE_BITS = 0,
  parameter int unsigned TOP_PRESCALE_BITS  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_scaler_bank_if.slave       wb,
  input  logic [15:0]           tda_scal_i,
  input  logic [15:0]           rsv_scal_i,
  input  logic [15:0]           l2_scal_i,
  input  logic [1:0]            l2_5_scal_i,
  input  logic                  top_self_i,
  input  logic                  top_surf_i,
  input  logic                  pps_flag_i,
  output logic [15:0]           debug_counter
);

  localparam int unsigned N_LANES  = 52;
  localparam int unsigned LANE_W   = 6;
  localparam int unsigned DBG_LANE = 28;

  // Lane layout: 0-15 TDA, 16-31 L2, 32-47 reserved, 48 top self,
  // 49 top surface, 50-51 L2.5. Matches the address-map ordering.
  function automatic int unsigned lane_pre(input int unsigned lane);
    if (lane < 16 || (lane >= 32 && lane < 48)) return L1_PRESCALE_BITS;
    else if (lane < 32)                         return L2_PRESCALE_BITS;
    else if (lane < 50)                         return TOP_PRESCALE_BITS;
    else                                        return L2_5_PRESCALE_BITS;
  endfunction

  logic [N_LANES-1:0] w_evt;
  logic               r_update;
  logic [15:0]        w_rd [N_LANES];

  assign w_evt = {l2_5_scal_i, top_surf_i, top_self_i, rsv_scal_i, l2_scal_i, tda_scal_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_update <= 1'b0;
    else       r_update <= pps_flag_i;
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    localparam int unsigned P = lane_pre(gi);
    localparam int unsigned W = 16 + P;

    logic [W-1:0] r_cnt;
    logic [15:0]  r_lat;
    logic [15:0]  r_rd;

    // PPS clears the counter and drops any event in that cycle.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt <= '0;
        r_lat <= '0;
        r_rd  <= '0;
      end else begin
        if (pps_flag_i) begin
          r_cnt <= '0;
          r_lat <= r_cnt[W-1:P];
        end else if (w_evt[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + W'(1);
        end
        if (r_update) r_rd <= r_lat;
      end
    end

    assign w_rd[gi] = r_rd;

    if (gi == DBG_LANE) begin : g_dbg
      assign debug_counter = r_cnt[15:0];
    end
  end

  logic [7:0]        w_adr;
  logic              w_hit;
  logic [LANE_W-1:0] w_lane;
  logic [15:0]       w_word;

  assign w_adr = wb.adr_i[7:0];

  // Address decode: adr[0] picks the byte, the rest selects a lane.
  always_comb begin
    w_hit  = 1'b0;
    w_lane = '0;
    case (w_adr[7:5])
      3'd0: begin
        w_hit  = (32'(w_adr[4:3]) < NUM_DAUGHTERS);
        w_lane = {2'b00, w_adr[4:1]};
      end
      3'd1: begin
        w_hit  = 1'b1;
        w_lane = {2'b01, w_adr[4:1]};
      end
      3'd2: begin
        w_hit  = (32'(w_adr[4:3]) < NUM_DAUGHTERS);
        w_lane = {2'b10, w_adr[4:1]};
      end
      3'd3: begin
        if (w_adr[4:3] == 2'b00) begin
          w_hit  = 1'b1;
          w_lane = {4'b1100, w_adr[2:1]};
        end
      end
      default: ;
    endcase
  end

  assign w_word   = w_rd[w_lane];
  assign wb.dat_o = !w_hit ? 8'h00 : (w_adr[0] ? w_word[15:8] : w_word[7:0]);
  assign wb.ack_o = wb.cyc_i & wb.stb_i;
  assign wb.err_o = 1'b0;
  assign wb.rty_o = 1'b0;

  logic w_unused;
  assign w_unused = ^{wb.wr_i, wb.dat_i, wb.adr_i[15:8]};

endmodule

// File: tb/tb_wb_scaler_bank.sv
// Self-checking bench for wb_scaler_bank: directed scenarios, a vector table,
// and randomized traffic against a count-per-scaler reference model.
module tb_wb_scaler_bank;

  localparam int ND = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] tda_scal_i, rsv_scal_i, l2_scal_i;
  logic [1:0]  l2_5_scal_i;
  logic        top_self_i, top_surf_i, pps_flag_i;
  logic [15:0] debug_counter;

  wb_scaler_bank_if wb ();

  wb_scaler_bank #(.NUM_DAUGHTERS(ND)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wb            (wb),
    .tda_scal_i    (tda_scal_i),
    .rsv_scal_i    (rsv_scal_i),
    .l2_scal_i     (l2_scal_i),
    .l2_5_scal_i   (l2_5_scal_i),
    .top_self_i    (top_self_i),
    .top_surf_i    (top_surf_i),
    .pps_flag_i    (pps_flag_i),
    .debug_counter (debug_counter)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model scaler numbering: 0-15 TDA, 16-31 reserved, 32-47 L2,
  // 48 top self, 49 top surface, 50-51 L2.5. Values are full counts.
  longint m_cnt [52];
  longint m_lat [52];
  longint m_rd  [52];
  bit     m_upd;

  typedef struct {
    logic [7:0] adr;
    logic [7:0] exp;
  } vec_t;

  vec_t t5 [9] = '{
    '{8'h60, 8'h05}, '{8'h61, 8'h00}, '{8'h62, 8'h07}, '{8'h63, 8'h00},
    '{8'h66, 8'h09}, '{8'h67, 8'h00}, '{8'h64, 8'h00}, '{8'h65, 8'h00},
    '{8'h70, 8'h00}
  };

  function automatic int pre_of(input int s);
    return (s < 32) ? 5 : 0;
  endfunction

  function automatic bit evt_of(input int s);
    if (s < 16)       return tda_scal_i[s];
    else if (s < 32)  return rsv_scal_i[s-16];
    else if (s < 48)  return l2_scal_i[s-32];
    else if (s == 48) return top_self_i;
    else if (s == 49) return top_surf_i;
    else              return l2_5_scal_i[s-50];
  endfunction

  task automatic model_step();
    if (rst_i) begin
      for (int s = 0; s < 52; s++) begin
        m_cnt[s] = 0; m_lat[s] = 0; m_rd[s] = 0;
      end
      m_upd = 0;
    end else begin
      if (m_upd) for (int s = 0; s < 52; s++) m_rd[s] = m_lat[s];
      for (int s = 0; s < 52; s++) begin
        longint mx;
        mx = (longint'(1) << (16 + pre_of(s))) - 1;
        if (pps_flag_i) begin
          m_lat[s] = m_cnt[s];
          m_cnt[s] = 0;
        end else if (evt_of(s) && m_cnt[s] < mx) begin
          m_cnt[s] = m_cnt[s] + 1;
        end
      end
      m_upd = pps_flag_i;
    end
  endtask

  function automatic logic [7:0] exp_byte(input int a);
    int s;
    longint v;
    if (a < 'h20) begin
      if (a / 8 >= ND) return 8'h00;
      s = a / 2;
    end else if (a < 'h40) begin
      s = 32 + (a - 'h20) / 2;
    end else if (a < 'h60) begin
      if ((a - 'h40) / 8 >= ND) return 8'h00;
      s = 16 + (a - 'h40) / 2;
    end else if (a < 'h62) s = 48;
    else if (a < 'h64)     s = 49;
    else if (a < 'h68)     s = 50 + (a - 'h64) / 2;
    else return 8'h00;
    v = m_rd[s] >> pre_of(s);
    return (a % 2 == 1) ? 8'((v >> 8) % 256) : 8'(v % 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_inputs();
    tda_scal_i = '0; rsv_scal_i = '0; l2_scal_i = '0; l2_5_scal_i = '0;
    top_self_i = 0; top_surf_i = 0; pps_flag_i = 0;
  endtask

  task automatic pps_pulse();
    pps_flag_i = 1;
    step();
    pps_flag_i = 0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    wb.cyc_i = 1; wb.stb_i = 1; wb.wr_i = 0; wb.adr_i = {8'h00, a};
    #1;
    check(name, 32'(wb.dat_o), 32'(exp));
    check({name, "_ack"}, 32'(wb.ack_o), 32'd1);
    wb.cyc_i = 0; wb.stb_i = 0;
    step();
  endtask

  initial begin
    wb.cyc_i = 0; wb.stb_i = 0; wb.wr_i = 0; wb.adr_i = '0; wb.dat_i = '0;
    clear_inputs();
    rst_i = 1;
    steps(2);
    rst_i = 0;
    check("reset_debug", 32'(debug_counter), 32'd0);
    check("err_o", 32'(wb.err_o), 32'd0);
    check("rty_o", 32'(wb.rty_o), 32'd0);

    // Reset before any PPS, with the input still asserted
    l2_scal_i[12] = 1;
    steps(20);
    check("pre_pps_debug", 32'(debug_counter), 32'd20);
    rst_i = 1;
    step();
    rst_i = 0;
    check("pre_pps_rst_debug", 32'(debug_counter), 32'd0);
    l2_scal_i = '0;

    // Test 1: readback after reset
    for (int a = 0; a < 'h68; a++) read_chk($sformatf("t1_rd_%02h", a), 8'(a), 8'h00);
    wb.cyc_i = 1; wb.stb_i = 0; #1;
    check("ack_no_stb", 32'(wb.ack_o), 32'd0);
    wb.cyc_i = 0;
    step();

    // Test 2: L1 prescale by 32
    tda_scal_i[5] = 1;
    steps(64);
    tda_scal_i = '0;
    pps_pulse();
    steps(2);
    read_chk("t2_0a", 8'h0A, 8'h02);
    read_chk("t2_0b", 8'h0B, 8'h00);
    read_chk("t2_4a", 8'h4A, 8'h00);
    pps_pulse();
    steps(2);
    read_chk("t2_0a_zero", 8'h0A, 8'h00);
    read_chk("t2_0b_zero", 8'h0B, 8'h00);

    // Test 3: saturation
    l2_scal_i[3] = 1;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (i % 10000 == 0) check("t3_debug", 32'(debug_counter), 32'd0);
    end
    l2_scal_i = '0;
    pps_pulse();
    steps(2);
    read_chk("t3_26", 8'h26, 8'hFF);
    read_chk("t3_27", 8'h27, 8'hFF);

    // Test 4: PPS mid-burst drops its own cycle
    for (int k = 0; k < 300; k++) begin
      l2_scal_i[12] = 1;
      pps_flag_i = (k == 200);
      step();
    end
    pps_flag_i = 0;
    l2_scal_i = '0;
    check("t4_debug", 32'(debug_counter), 32'd99);
    read_chk("t4_38", 8'h38, 8'hC8);
    read_chk("t4_39", 8'h39, 8'h00);

    // Test 5: top and L2.5 scalers, vector table
    top_self_i = 1; steps(5); top_self_i = 0;
    top_surf_i = 1; steps(7); top_surf_i = 0;
    l2_5_scal_i[1] = 1; steps(9); l2_5_scal_i = '0;
    pps_pulse();
    steps(2);
    for (int i = 0; i < 9; i++) read_chk($sformatf("t5_%02h", t5[i].adr), t5[i].adr, t5[i].exp);
    wb.cyc_i = 1; wb.stb_i = 1; wb.wr_i = 1; wb.adr_i = 16'h0060; wb.dat_i = 8'hAA;
    #1;
    check("t5_wr_ack", 32'(wb.ack_o), 32'd1);
    step();
    wb.cyc_i = 0; wb.stb_i = 0; wb.wr_i = 0;
    read_chk("t5_60_after_wr", 8'h60, 8'h05);

    // Test 6: reset after a latched value
    l2_scal_i[12] = 1;
    steps(10);
    check("t6_debug", 32'(debug_counter), 32'd10);
    rst_i = 1;
    step();
    rst_i = 0;
    l2_scal_i = '0;
    check("t6_rst_debug", 32'(debug_counter), 32'd0);
    read_chk("t6_60", 8'h60, 8'h00);
    read_chk("t6_38", 8'h38, 8'h00);
    read_chk("t6_70", 8'h70, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      tda_scal_i  = 16'($urandom);
      rsv_scal_i  = 16'($urandom);
      l2_scal_i   = 16'($urandom);
      l2_5_scal_i = 2'($urandom);
      top_self_i  = 1'($urandom);
      top_surf_i  = 1'($urandom);
      pps_flag_i  = ($urandom_range(0, 31) == 0);
      rst_i       = ($urandom_range(0, 999) == 0);
      wb.cyc_i    = 1'($urandom);
      wb.stb_i    = 1'($urandom);
      wb.wr_i     = 1'($urandom);
      wb.dat_i    = 8'($urandom);
      wb.adr_i    = 16'($urandom);
      if (n % 2 == 0) wb.adr_i[7] = 1'b0;
      #1;
      check("rnd_dat", 32'(wb.dat_o), 32'(exp_byte(int'(wb.adr_i[7:0]))));
      check("rnd_ack", 32'(wb.ack_o), 32'(wb.cyc_i & wb.stb_i));
      check("rnd_debug", 32'(debug_counter), 32'(m_cnt[44] % 65536));
      step();
    end
    rst_i = 0;
    clear_inputs();
    wb.cyc_i = 0; wb.stb_i = 0; wb.wr_i = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
